// File: rtl/tick_pkg.sv
// Shared timer definitions: state encoding for the tick monitor and the tick period
// constants, so the timer and its monitor agree on one period source.
package tick_pkg;

   typedef enum logic [1:0] {
      WAIT_FIRST = 2'd0,
      MEASURE    = 2'd1,
      LATE       = 2'd2
   } tick_state_e;

   localparam int TICK_PERIOD_50MHZ = 25000000;
   localparam int TICK_PERIOD_SIM   = 6;

endpackage

// File: rtl/tick_monitor.sv
// Measures clk spacing between timer tick strobes, flags early/late ticks, reports lock.
// All outputs registered; every response appears one clk after the sampled tick.
module tick_monitor
   import tick_pkg::*;
#(
   parameter int PERIOD = TICK_PERIOD_50MHZ,
   parameter int TOL    = 0,
   parameter int LOCK_N = 4,
   parameter int CW     = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_i,
   input  logic          clear_i,
   output logic [CW-1:0] period_o,
   output logic          period_valid_o,
   output logic          early_o,
   output logic          late_o,
   output logic          err_sticky_o,
   output logic          locked_o,
   output logic [15:0]   tick_cnt_o
);

   localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [GW-1:0] LOCK_GR  = GW'(LOCK_N);
   localparam logic [CW-1:0] LATE_TH  = CW'(PERIOD + TOL + 1);
   // A zero threshold makes the early compare unreachable when TOL swallows the period.
   localparam logic [CW-1:0] EARLY_TH = (TOL >= PERIOD) ? '0 : CW'(PERIOD - TOL);

   tick_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] gr_q, gr_d, gr_inc;
   logic [CW-1:0] period_q, period_d;
   logic          pv_q, pv_d;
   logic          early_q, early_d;
   logic          late_q, late_d;
   logic          err_q, err_d;
   logic          locked_q, locked_d;
   logic [15:0]   tick_cnt_q, tick_cnt_d;
   logic          err_set;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gr_d     = gr_q;
      period_d = period_q;
      pv_d     = 1'b0;
      early_d  = 1'b0;
      late_d   = 1'b0;
      locked_d = locked_q;
      err_set  = 1'b0;
      gr_inc   = (gr_q == LOCK_GR) ? gr_q : gr_q + GW'(1);

      case (state_q)
         WAIT_FIRST: begin
            if (tick_i) begin
               state_d = MEASURE;
               cnt_d   = CW'(1);
            end
         end
         MEASURE: begin
            if (tick_i) begin
               period_d = cnt_q;
               pv_d     = 1'b1;
               cnt_d    = CW'(1);
               // A tick landing on the late threshold still reports its period but counts as late.
               if (cnt_q == LATE_TH) begin
                  late_d   = 1'b1;
                  err_set  = 1'b1;
                  locked_d = 1'b0;
                  gr_d     = '0;
               end else if (cnt_q < EARLY_TH) begin
                  early_d  = 1'b1;
                  err_set  = 1'b1;
                  locked_d = 1'b0;
                  gr_d     = '0;
               end else begin
                  gr_d = gr_inc;
                  if (gr_inc == LOCK_GR) locked_d = 1'b1;
               end
            end else if (cnt_q == LATE_TH) begin
               late_d   = 1'b1;
               err_set  = 1'b1;
               locked_d = 1'b0;
               gr_d     = '0;
               state_d  = LATE;
               cnt_d    = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         LATE: begin
            if (tick_i) begin
               period_d = cnt_q;
               pv_d     = 1'b1;
               cnt_d    = CW'(1);
               state_d  = MEASURE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = WAIT_FIRST;
      endcase

      tick_cnt_d = (clear_i ? 16'd0 : tick_cnt_q) + {15'd0, tick_i};
      err_d      = err_set | (err_q & ~clear_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= WAIT_FIRST;
         cnt_q      <= '0;
         gr_q       <= '0;
         period_q   <= '0;
         pv_q       <= 1'b0;
         early_q    <= 1'b0;
         late_q     <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         tick_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gr_q       <= gr_d;
         period_q   <= period_d;
         pv_q       <= pv_d;
         early_q    <= early_d;
         late_q     <= late_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         tick_cnt_q <= tick_cnt_d;
      end
   end

   assign period_o       = period_q;
   assign period_valid_o = pv_q;
   assign early_o        = early_q;
   assign late_o         = late_q;
   assign err_sticky_o   = err_q;
   assign locked_o       = locked_q;
   assign tick_cnt_o     = tick_cnt_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Scoreboard bench for tick_monitor: a time-based reference model pushes the expected
// registered outputs for every driven cycle, popped and compared one edge later.
module tb_tick_monitor;
   import tick_pkg::*;

   localparam int P       = TICK_PERIOD_SIM;
   localparam int TOL     = 1;
   localparam int LOCKN   = 3;
   localparam int CW      = 8;
   localparam int LATE_AT = P + TOL + 1;

   typedef struct packed {
      logic [CW-1:0] period;
      logic          pv;
      logic          early;
      logic          late;
      logic          err;
      logic          locked;
      logic [15:0]   cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick_i = 1'b0;
   logic          clear_i = 1'b0;
   logic [CW-1:0] period_o;
   logic          period_valid_o;
   logic          early_o;
   logic          late_o;
   logic          err_sticky_o;
   logic          locked_o;
   logic [15:0]   tick_cnt_o;

   tick_monitor #(.PERIOD(P), .TOL(TOL), .LOCK_N(LOCKN), .CW(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .tick_i         (tick_i),
      .clear_i        (clear_i),
      .period_o       (period_o),
      .period_valid_o (period_valid_o),
      .early_o        (early_o),
      .late_o         (late_o),
      .err_sticky_o   (err_sticky_o),
      .locked_o       (locked_o),
      .tick_cnt_o     (tick_cnt_o)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;

   // Reference model state, kept in elapsed-time terms rather than a running counter.
   bit   m_started, m_late_done, m_locked, m_err;
   int   m_last, m_good, m_period, m_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic model(input logic t, input logic c, input logic r, output exp_t e);
      int el;
      bit set;
      e   = '0;
      set = 1'b0;
      if (r) begin
         m_started = 0; m_late_done = 0; m_locked = 0; m_err = 0;
         m_good = 0; m_period = 0; m_cnt = 0; m_last = 0;
      end else begin
         el = cyc - m_last;
         if (el > 255) el = 255;
         if (m_started && t) begin
            m_period = el;
            e.pv     = 1'b1;
            if (!m_late_done) begin
               if (el == LATE_AT) begin
                  e.late = 1'b1; set = 1'b1; m_good = 0; m_locked = 0;
               end else if (el < P - TOL) begin
                  e.early = 1'b1; set = 1'b1; m_good = 0; m_locked = 0;
               end else begin
                  if (m_good < LOCKN) m_good++;
                  if (m_good == LOCKN) m_locked = 1;
               end
            end
            m_late_done = 0;
            m_last      = cyc;
         end else if (m_started && !m_late_done && el == LATE_AT) begin
            e.late = 1'b1; set = 1'b1; m_good = 0; m_locked = 0; m_late_done = 1;
         end else if (!m_started && t) begin
            m_started = 1;
            m_last    = cyc;
         end
         m_cnt = ((c ? 0 : m_cnt) + (t ? 1 : 0)) & 16'hFFFF;
         m_err = set || (m_err && !c);
      end
      e.period = CW'(m_period);
      e.err    = m_err;
      e.locked = m_locked;
      e.cnt    = 16'(m_cnt);
   endtask

   task automatic step(input logic t, input logic c, input logic r);
      exp_t e;
      tick_i  = t;
      clear_i = c;
      rst     = r;
      model(t, c, r, e);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk("queue_underflow", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk("period_o",       32'(period_o),       32'(e.period));
         chk("period_valid_o", 32'(period_valid_o), 32'(e.pv));
         chk("early_o",        32'(early_o),        32'(e.early));
         chk("late_o",         32'(late_o),         32'(e.late));
         chk("err_sticky_o",   32'(err_sticky_o),   32'(e.err));
         chk("locked_o",       32'(locked_o),       32'(e.locked));
         chk("tick_cnt_o",     32'(tick_cnt_o),     32'(e.cnt));
      end
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
   endtask

   // Tick arriving n cycles after the previous one, optionally with clear in the tick cycle.
   task automatic gap(input int n, input logic clr);
      idle(n - 1);
      step(1'b1, clr, 1'b0);
   endtask

   initial begin
      #1;
      // 1: reset, then five ticks 6 apart
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) gap(6, 1'b0);
      // 2: early tick then relock
      gap(3, 1'b0);
      for (int i = 0; i < 4; i++) gap(6, 1'b0);
      // 3: withheld tick goes late, closes at 12
      gap(12, 1'b0);
      for (int i = 0; i < 3; i++) gap(6, 1'b0);
      // 4: tick exactly on the late threshold, then clear racing an early tick
      gap(8, 1'b0);
      gap(2, 1'b1);
      gap(6, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      gap(6, 1'b0);
      gap(5, 1'b0);
      gap(7, 1'b0);
      // 5: tick held high three cycles
      gap(6, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      gap(6, 1'b0);
      // 6: reset mid-measurement
      idle(3);
      step(1'b0, 1'b0, 1'b1);
      idle(2);
      step(1'b1, 1'b0, 1'b0);
      gap(6, 1'b0);
      gap(6, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
